// File: rtl/uart_rx_pkg.sv
// Shared types and defaults for the UART receive sequencer.
package uart_rx_pkg;

    // Default frame geometry: data bits per frame and edge-counter width.
    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 6;

    // Oversampling ratio used at reset and whenever Prescale holds an
    // unsupported value.
    localparam int PRESCALE_DEFAULT = 8;

    // Receive sequencer states, in frame order.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } rx_state_e;

    // Map a requested oversampling ratio onto the supported set {8,16,32}.
    // Anything else falls back to the default so the counter always wraps at
    // a sane point.
    function automatic int legal_prescale(input int req);
        int res;
        res = PRESCALE_DEFAULT;
        if (req == 8 || req == 16 || req == 32) begin
            res = req;
        end
        return res;
    endfunction

endpackage : uart_rx_pkg

// File: rtl/rx_edge_bit_cnt.sv
// Edge (oversample) counter and bit counter for the UART receiver.
// edge_cnt_o counts 0..prescale_i-1 inside a bit; bit_cnt_o counts
// completed data bits. clear_i has priority over load1_i, which has
// priority over normal counting.
module rx_edge_bit_cnt
    import uart_rx_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int BIT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic             clear_i,
    input  logic             load1_i,
    input  logic             bit_inc_i,
    input  logic [CNT_W-1:0] prescale_i,
    output logic [CNT_W-1:0] edge_cnt_o,
    output logic [BIT_W-1:0] bit_cnt_o,
    output logic             bit_end_o
);

    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             bit_end;

    assign bit_end = (edge_cnt_q == (prescale_i - CNT_W'(1)));

    // Next-state for the edge counter: load 1 on start detect (the detect
    // cycle itself is edge 0), otherwise wrap at the end of each bit.
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        if (clear_i) begin
            edge_cnt_d = '0;
        end else if (load1_i) begin
            edge_cnt_d = CNT_W'(1);
        end else if (enable_i) begin
            edge_cnt_d = bit_end ? '0 : (edge_cnt_q + CNT_W'(1));
        end
    end

    // Next-state for the bit counter: restart on every new frame, advance
    // once per received data bit.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (clear_i || load1_i) begin
            bit_cnt_d = '0;
        end else if (bit_inc_i) begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign edge_cnt_o = edge_cnt_q;
    assign bit_cnt_o  = bit_cnt_q;
    assign bit_end_o  = bit_end;

endmodule : rx_edge_bit_cnt

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: detects the start bit, drives the oversampling
// position to the external majority-vote sampler, deserialises DATA_W bits
// LSB-first, checks optional parity and the stop bit, and presents the byte
// with one-cycle strobes. Strobes and P_DATA are registered at the end of
// the stop bit so they are visible during the single DONE cycle.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              fast_clk,
    input  logic              rst,
    input  logic              RX_IN,
    input  logic [CNT_W-1:0]  Prescale,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    input  logic              sampled_bit,
    output logic              dat_samp_en,
    output logic [CNT_W-1:0]  edge_cnt,
    output logic [CNT_W-1:0]  samp_prescale,
    output logic [DATA_W-1:0] P_DATA,
    output logic              data_valid,
    output logic              par_err,
    output logic              stp_err,
    output logic              busy
);

    localparam int BIT_W = $clog2(DATA_W) + 1;

    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  prescale_q, prescale_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] pdata_q, pdata_d;
    logic              perr_q, perr_d;
    logic              dv_q, dv_d;
    logic              pe_q, pe_d;
    logic              se_q, se_d;

    logic              cnt_en;
    logic              cnt_clear;
    logic              cnt_load1;
    logic              bit_inc;
    logic [BIT_W-1:0]  bit_cnt;
    logic              bit_end;
    logic              frame_good;

    rx_edge_bit_cnt #(
        .CNT_W (CNT_W),
        .BIT_W (BIT_W)
    ) u_cnt (
        .clk        (fast_clk),
        .rst        (rst),
        .enable_i   (cnt_en),
        .clear_i    (cnt_clear),
        .load1_i    (cnt_load1),
        .bit_inc_i  (bit_inc),
        .prescale_i (prescale_q),
        .edge_cnt_o (edge_cnt),
        .bit_cnt_o  (bit_cnt),
        .bit_end_o  (bit_end)
    );

    // A frame is delivered only if parity (when present) matched and the
    // stop bit sampled high.
    assign frame_good = !perr_q && sampled_bit;

    // Next-state, counter control, shift/parity datapath and strobe logic.
    always_comb begin
        state_d    = state_q;
        prescale_d = prescale_q;
        shift_d    = shift_q;
        pdata_d    = pdata_q;
        perr_d     = perr_q;
        dv_d       = 1'b0;
        pe_d       = 1'b0;
        se_d       = 1'b0;
        cnt_en     = 1'b0;
        cnt_clear  = 1'b0;
        cnt_load1  = 1'b0;
        bit_inc    = 1'b0;

        case (state_q)
            IDLE: begin
                // Ratio is only taken between frames; a change while a frame
                // is in flight has no effect until the line returns to idle.
                prescale_d = CNT_W'(legal_prescale(int'(Prescale)));
                if (!RX_IN) begin
                    state_d   = START;
                    cnt_load1 = 1'b1;
                end else begin
                    cnt_clear = 1'b1;
                end
            end

            START: begin
                cnt_en = 1'b1;
                if (bit_end) begin
                    // Line back high at mid-bit: noise, not a start bit.
                    state_d = sampled_bit ? IDLE : DATA;
                end
            end

            DATA: begin
                cnt_en = 1'b1;
                if (bit_end) begin
                    shift_d = {sampled_bit, shift_q[DATA_W-1:1]};
                    bit_inc = 1'b1;
                    if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                        state_d = PAR_EN ? PARITY : STOP;
                    end
                end
            end

            PARITY: begin
                cnt_en = 1'b1;
                if (bit_end) begin
                    perr_d  = sampled_bit != (^shift_q ^ PAR_TYP);
                    state_d = STOP;
                end
            end

            STOP: begin
                cnt_en = 1'b1;
                if (bit_end) begin
                    dv_d    = frame_good;
                    pe_d    = perr_q;
                    se_d    = !sampled_bit;
                    if (frame_good) begin
                        pdata_d = shift_q;
                    end
                    state_d = DONE;
                end
            end

            DONE: begin
                perr_d = 1'b0;
                // A low line here is the next start bit arriving with no
                // idle gap; this cycle is its edge 0.
                if (!RX_IN) begin
                    state_d   = START;
                    cnt_load1 = 1'b1;
                end else begin
                    state_d   = IDLE;
                    cnt_clear = 1'b1;
                end
            end

            default: begin
                state_d   = IDLE;
                cnt_clear = 1'b1;
            end
        endcase
    end

    // State, datapath and strobe registers.
    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            prescale_q <= CNT_W'(PRESCALE_DEFAULT);
            shift_q    <= '0;
            pdata_q    <= '0;
            perr_q     <= 1'b0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            se_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            prescale_q <= prescale_d;
            shift_q    <= shift_d;
            pdata_q    <= pdata_d;
            perr_q     <= perr_d;
            dv_q       <= dv_d;
            pe_q       <= pe_d;
            se_q       <= se_d;
        end
    end

    assign dat_samp_en   = (state_q == START) || (state_q == DATA) ||
                           (state_q == PARITY) || (state_q == STOP);
    assign busy          = (state_q != IDLE);
    assign samp_prescale = prescale_q;
    assign P_DATA        = pdata_q;
    assign data_valid    = dv_q;
    assign par_err       = pe_q;
    assign stp_err       = se_q;

endmodule : uart_rx_ctrl

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed frames with hand-computed results pushed
// to a scoreboard queue; a monitor pops one entry per strobe and compares
// flags, byte and arrival cycle.
module tb_uart_rx_ctrl;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 6;

    logic              fast_clk = 1'b0;
    logic              rst;
    logic              RX_IN;
    logic [CNT_W-1:0]  Prescale;
    logic              PAR_EN;
    logic              PAR_TYP;
    logic              sampled_bit;
    logic              dat_samp_en;
    logic [CNT_W-1:0]  edge_cnt;
    logic [CNT_W-1:0]  samp_prescale;
    logic [DATA_W-1:0] P_DATA;
    logic              data_valid;
    logic              par_err;
    logic              stp_err;
    logic              busy;

    uart_rx_ctrl #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .fast_clk      (fast_clk),
        .rst           (rst),
        .RX_IN         (RX_IN),
        .Prescale      (Prescale),
        .PAR_EN        (PAR_EN),
        .PAR_TYP       (PAR_TYP),
        .sampled_bit   (sampled_bit),
        .dat_samp_en   (dat_samp_en),
        .edge_cnt      (edge_cnt),
        .samp_prescale (samp_prescale),
        .P_DATA        (P_DATA),
        .data_valid    (data_valid),
        .par_err       (par_err),
        .stp_err       (stp_err),
        .busy          (busy)
    );

    always #5 fast_clk = ~fast_clk;

    int cyc = 0;
    always @(posedge fast_clk) cyc <= cyc + 1;

    // Simple mid-bit sampler standing in for the majority-vote block.
    always @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            sampled_bit <= 1'b1;
        end else if (dat_samp_en && (edge_cnt == (samp_prescale >> 1))) begin
            sampled_bit <= RX_IN;
        end
    end

    typedef struct {
        int          id;
        logic        dv;
        logic        pe;
        logic        se;
        logic [7:0]  data;
        int          at_cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
        end
    endtask

    // Monitor: every strobe consumes exactly one scoreboard entry.
    always @(negedge fast_clk) begin
        if (!rst && (data_valid || par_err || stp_err)) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: cyc=%0d dv=%0b pe=%0b se=%0b data=0x%0h required no strobe",
                         cyc, data_valid, par_err, stp_err, P_DATA);
            end else begin
                mon_e = sb_q.pop_front();
                $display("frame %0d: cyc=%0d dv=%0b pe=%0b se=%0b data=0x%02h",
                         mon_e.id, cyc, data_valid, par_err, stp_err, P_DATA);
                check($sformatf("frame%0d_data_valid", mon_e.id), 32'(data_valid), 32'(mon_e.dv));
                check($sformatf("frame%0d_par_err", mon_e.id), 32'(par_err), 32'(mon_e.pe));
                check($sformatf("frame%0d_stp_err", mon_e.id), 32'(stp_err), 32'(mon_e.se));
                check($sformatf("frame%0d_P_DATA", mon_e.id), 32'(P_DATA), 32'(mon_e.data));
                check($sformatf("frame%0d_arrival_cyc", mon_e.id), 32'(cyc), 32'(mon_e.at_cyc));
            end
        end
    end

    // All stimulus tasks start and end 1 ns after a rising edge.
    task automatic send_bit(input logic b, input int p);
        RX_IN = b;
        repeat (p) @(posedge fast_clk);
        #1;
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(posedge fast_clk);
        #1;
    endtask

    // One frame: start, 8 data bits LSB first, optional parity, stop.
    // Expected flags/byte come from the caller; arrival cycle is
    // (10 + parity) bit times after the falling edge.
    task automatic send_frame(input int id, input logic [7:0] d, input int p,
                              input logic pen, input logic ptyp, input logic pbit,
                              input logic stopb, input logic edv, input logic epe,
                              input logic ese, input logic [7:0] edata);
        exp_t e;
        PAR_EN  = pen;
        PAR_TYP = ptyp;
        e.id     = id;
        e.dv     = edv;
        e.pe     = epe;
        e.se     = ese;
        e.data   = edata;
        e.at_cyc = cyc + (pen ? 11 : 10) * p;
        sb_q.push_back(e);
        send_bit(1'b0, p);
        for (int i = 0; i < 8; i++) send_bit(d[i], p);
        if (pen) send_bit(pbit, p);
        send_bit(stopb, p);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        RX_IN    = 1'b1;
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        repeat (3) @(posedge fast_clk);
        #1;
        check("reset_busy",        32'(busy),          32'd0);
        check("reset_dat_samp_en", 32'(dat_samp_en),  32'd0);
        check("reset_edge_cnt",    32'(edge_cnt),      32'd0);
        check("reset_P_DATA",      32'(P_DATA),        32'd0);
        check("reset_data_valid",  32'(data_valid),    32'd0);
        check("reset_par_err",     32'(par_err),       32'd0);
        check("reset_stp_err",     32'(stp_err),       32'd0);
        check("reset_prescale",    32'(samp_prescale), 32'd8);
        rst = 1'b0;
        idle(3);

        // P=8, no parity, 0xA5 -> good, latency 80.
        send_frame(1, 8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5);
        idle(5);

        // P=16, even parity: 0x3C has four ones -> parity bit 0 is good.
        Prescale = 6'd16;
        idle(3);
        check("prescale_latch_16", 32'(samp_prescale), 32'd16);
        send_frame(2, 8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C);
        idle(5);
        // Same frame with parity bit 1 -> parity error, byte held at 0x3C.
        send_frame(3, 8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C);
        idle(5);

        // P=8, odd parity: 0x07 has three ones -> parity bit 0 is good.
        Prescale = 6'd8;
        idle(3);
        send_frame(4, 8'h07, 8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h07);
        idle(5);

        // P=8, 0x81 with stop bit 0 -> stop error, byte held at 0x07.
        send_frame(5, 8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h07);
        idle(3);
        check("stp_err_back_to_idle", 32'(busy), 32'd0);

        // Start glitch: low for 3 cycles; busy holds for the remainder of
        // the 8-cycle start bit and then drops with no strobe.
        RX_IN = 1'b0;
        repeat (3) @(posedge fast_clk);
        #1;
        RX_IN = 1'b1;
        check("glitch_busy_early", 32'(busy), 32'd1);
        repeat (4) @(posedge fast_clk);
        #1;
        check("glitch_busy_last", 32'(busy), 32'd1);
        @(posedge fast_clk);
        #1;
        check("glitch_busy_dropped", 32'(busy), 32'd0);
        idle(5);

        // Back-to-back 0x12, 0x34 at P=32; Prescale moves to 8 inside
        // frame 1 and must not affect either frame.
        Prescale = 6'd32;
        idle(3);
        fork
            send_frame(6, 8'h12, 32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h12);
            begin
                repeat (50) @(posedge fast_clk);
                #1;
                Prescale = 6'd8;
            end
        join
        check("b2b_prescale_held", 32'(samp_prescale), 32'd32);
        send_frame(7, 8'h34, 32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h34);
        idle(5);
        check("prescale_relatch_8", 32'(samp_prescale), 32'd8);

        // Reset mid-DATA: start bit plus two data bits, then async reset
        // between clock edges.
        send_bit(1'b0, 8);
        send_bit(1'b1, 8);
        send_bit(1'b0, 8);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_busy",        32'(busy),          32'd0);
        check("midrst_dat_samp_en", 32'(dat_samp_en),  32'd0);
        check("midrst_edge_cnt",    32'(edge_cnt),      32'd0);
        check("midrst_P_DATA",      32'(P_DATA),        32'd0);
        check("midrst_data_valid",  32'(data_valid),    32'd0);
        check("midrst_par_err",     32'(par_err),       32'd0);
        check("midrst_stp_err",     32'(stp_err),       32'd0);
        check("midrst_prescale",    32'(samp_prescale), 32'd8);
        RX_IN = 1'b1;
        @(posedge fast_clk);
        #1;
        rst = 1'b0;
        idle(4);
        send_frame(8, 8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h55);
        idle(10);

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uart_rx_ctrl

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side sequencer for the UART. Detects the start bit and generates `edge_cnt` and `dat_samp_en` for the majority-vote bit sampler.
- Consumes the sampler's `sampled_bit` at each bit boundary, deserialises 8 data bits LSB-first, and checks optional parity and the stop bit.
- Presents a parallel byte to the ALU command path with a one-cycle valid strobe.
- Sits between the `RX_IN` pin and the ALU front end, alongside the sampler.

Parameters:
- DATA_W, 8, data bits per frame.
- CNT_W, 6, width of the edge counter and of Prescale.

Ports:
- fast_clk  in  1  oversampling clock; shared with the sampler.
- rst  in  1  asynchronous, active-high reset.
- RX_IN  in  1  serial line; idle high; already synchronised upstream.
- Prescale  in  CNT_W  oversampling ratio; legal values 8, 16, 32.
- PAR_EN  in  1  1 = frame carries a parity bit.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- sampled_bit  in  1  sampler result.
- dat_samp_en  out  1  sampler enable.
- edge_cnt  out  CNT_W  position inside the current bit, 0..Prescale_q-1.
- samp_prescale  out  CNT_W  latched Prescale (Prescale_q); drives the sampler's Prescale input.
- P_DATA  out  DATA_W  received byte.
- data_valid  out  1  one-cycle strobe: P_DATA is a good frame.
- par_err  out  1  one-cycle strobe: parity mismatch.
- stp_err  out  1  one-cycle strobe: stop bit was 0.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst=1):
  - State = IDLE.
  - edge_cnt=0, bit_cnt=0, shift register=0.
  - P_DATA=0, data_valid=par_err=stp_err=0, dat_samp_en=0, busy=0.
  - Prescale_q=8.
  - Reset asserted mid-frame aborts the frame; no strobe is issued.
- States: IDLE, START, DATA, PARITY, STOP, DONE.
- Bit end: `bit_end = (edge_cnt == Prescale_q-1)`.
  - In START/DATA/PARITY/STOP, edge_cnt increments every cycle and wraps to 0 at bit_end.
  - dat_samp_en=1 in START/DATA/PARITY/STOP, 0 in IDLE and DONE.
- IDLE:
  - On RX_IN==0: go to START, edge_cnt<=1 (the detect cycle counts as edge 0).
  - Latch Prescale into Prescale_q; any value other than 8/16/32 latches as 8.
  - Prescale changes mid-frame are ignored.
- START: at bit_end, sampled_bit==1 is a glitch: return to IDLE with no strobe. Otherwise go to DATA with bit_cnt=0.
- DATA:
  - At bit_end, shift right with sampled_bit entering the MSB (LSB-first on the line), then bit_cnt++.
  - After the bit with bit_cnt==DATA_W-1, go to PARITY if PAR_EN, else STOP.
- PARITY: at bit_end, perr <= sampled_bit != (^shift ^ PAR_TYP); go to STOP.
- STOP: at bit_end, serr <= !sampled_bit; go to DONE.
- DONE (exactly one cycle):
  - data_valid = !perr && !serr.
  - par_err = perr; stp_err = serr.
  - P_DATA <= shift only when the frame is good; otherwise P_DATA holds its previous value.
  - perr/serr clear.
  - If RX_IN==0, go directly to START with edge_cnt<=1 (back-to-back frames); else go to IDLE.
- Timing:
  - Strobes are registered outputs, asserted in the DONE cycle.
  - Latency from the start-bit falling edge to data_valid = (10 + PAR_EN) × Prescale_q cycles.
- PAR_EN/PAR_TYP are sampled live; they must be static during a frame.
- No backpressure: the consumer must accept data_valid unconditionally.

Decomposition:
- Package uart_rx_pkg:
  - enum rx_state_e {IDLE, START, DATA, PARITY, STOP, DONE}.
  - DATA_W and CNT_W defaults.
  - PRESCALE_DEFAULT = 8.
- Sub-module rx_edge_bit_cnt:
  - Inputs: enable, Prescale_q.
  - Outputs: edge_cnt, bit_cnt, bit_end.
  - Clear and load-to-1 controls.
- The FSM, shift register, parity and stop checks stay in uart_rx_ctrl.

Test Plan:
- Prescale=8, PAR_EN=0, frame 0xA5 → data_valid pulse 80 cycles after the falling edge, P_DATA=0xA5, no errors.
- Prescale=16, PAR_EN=1, PAR_TYP=0, byte 0x3C with parity bit 0 → data_valid, P_DATA=0x3C. Same frame with parity bit 1 → par_err pulse, data_valid=0, P_DATA unchanged.
- Prescale=8, 0x81 with stop bit 0 → stp_err pulse, no data_valid; FSM returns to IDLE once RX_IN is high.
- RX_IN low for 3 cycles then high (Prescale=8) → start glitch rejected; busy drops after 8 cycles; no strobes.
- Two back-to-back frames 0x12, 0x34 (Prescale=32, no idle gap) → two data_valid pulses exactly 320 cycles apart with correct bytes. Prescale changed to 8 during frame 1 → frame 1 is unaffected.
- rst pulsed during the DATA state → all outputs return to 0 asynchronously; next frame 0x55 is received correctly.
